chacha20_xor_stream: RTL and testbench

//  Downstream consumer of the ChaCha20 keystream generator (state + block core).

---
 rtl/chacha20_xor_stream.sv | 169 ++++++++++++++++
 tb/tb_chacha20_xor_stream.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_xor_stream.sv
// Keystream XOR stage: fetches 512-bit ChaCha20 blocks from the core and XORs them onto a word stream.
// Optional macro CHACHA20_CTR_WRAP_ERR_EN adds a sticky ctr_wrap_err output that halts on counter wrap.
module chacha20_xor_stream #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [31:0]       ctr_init,
    output logic              core_start,
    output logic [31:0]       core_counter,
    input  logic              ks_done,
    input  logic [511:0]      ks_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
`ifdef CHACHA20_CTR_WRAP_ERR_EN
    ,
    output logic              ctr_wrap_err
`endif
);

    localparam int WORDS = 512 / DATA_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STREAM
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [31:0]        counter_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [511:0]       ks_buf_reg;
    logic               out_valid_reg;
    logic [DATA_W-1:0]  out_data_reg;
    logic               out_last_reg;

    logic               accept;
    logic               block_last;
    logic               ctr_step;
    logic               wrap_err;
    logic               wrap_stop;
    logic [DATA_W-1:0]  ks_word [WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_ks_word
            assign ks_word[gi] = ks_buf_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign core_start   = (state_reg == ST_REQ);
    assign busy         = (state_reg != ST_IDLE);
    assign in_ready     = (state_reg == ST_STREAM) && (!out_valid_reg || out_ready);
    assign core_counter = counter_reg;
    assign out_valid    = out_valid_reg;
    assign out_data     = out_data_reg;
    assign out_last     = out_last_reg;

    assign accept     = in_valid && in_ready;
    assign block_last = (idx_reg == LAST_IDX);
    // Counter advances once per block used, whether the message ended early or the block ran out.
    assign ctr_step   = accept && (in_last || block_last);

`ifdef CHACHA20_CTR_WRAP_ERR_EN
    logic wrap_err_reg;
    logic ctr_wraps;

    assign ctr_wraps    = ctr_step && (counter_reg == 32'hFFFF_FFFF);
    assign wrap_stop    = ctr_wraps;
    assign wrap_err     = wrap_err_reg;
    assign ctr_wrap_err = wrap_err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_err_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && init) begin
            wrap_err_reg <= 1'b0;
        end else if (ctr_wraps) begin
            wrap_err_reg <= 1'b1;
        end
    end
`else
    assign wrap_stop = 1'b0;
    assign wrap_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!init && in_valid && !wrap_err) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (ks_done) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A wrapped counter parks the FSM in IDLE instead of fetching another block.
                if (accept && (in_last || wrap_stop)) begin
                    state_next = ST_IDLE;
                end else if (accept && block_last) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_reg   <= 32'd0;
            idx_reg       <= '0;
            ks_buf_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && init) begin
                counter_reg <= ctr_init;
            end else if (ctr_step) begin
                counter_reg <= counter_reg + 32'd1;
            end

            if (state_reg == ST_WAIT && ks_done) begin
                ks_buf_reg <= ks_in;
                idx_reg    <= '0;
            end else if (accept) begin
                idx_reg <= (in_last || block_last) ? '0 : idx_reg + IDX_W'(1);
            end

            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= in_data ^ ks_word[idx_reg];
                out_last_reg  <= in_last;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_chacha20_xor_stream.sv
// Randomized bench for chacha20_xor_stream with a mock keystream core and a message-level model.
module tb_chacha20_xor_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic [31:0]  ctr_init;
    logic         core_start;
    logic [31:0]  core_counter;
    logic         ks_done;
    logic [511:0] ks_in;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;
`ifdef CHACHA20_CTR_WRAP_ERR_EN
    logic         ctr_wrap_err;
`endif

    always #5 clk = ~clk;

    chacha20_xor_stream #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .init(init), .ctr_init(ctr_init),
        .core_start(core_start), .core_counter(core_counter),
        .ks_done(ks_done), .ks_in(ks_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
`ifdef CHACHA20_CTR_WRAP_ERR_EN
        , .ctr_wrap_err(ctr_wrap_err)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- keystream definition and mock core ----------------
    bit           mix = 1'b0;
    logic         spur = 1'b0;
    logic [511:0] garbage = '0;
    logic [31:0]  mock_ctr;
    logic         mock_done;
    int           mock_delay;

    function automatic logic [31:0] ks_word(input logic [31:0] c, input int i);
        logic [31:0] ii;
        ii = i;
        return mix ? (c ^ (ii * 32'h9E37_79B1 + 32'h0123_4567)) : c;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mock_delay <= 0;
            mock_done  <= 1'b0;
            mock_ctr   <= 32'd0;
        end else begin
            mock_done <= 1'b0;
            if (core_start) begin
                mock_delay <= 3;
                mock_ctr   <= core_counter;
            end else if (mock_delay != 0) begin
                mock_delay <= mock_delay - 1;
                if (mock_delay == 1) mock_done <= 1'b1;
            end
        end
    end

    assign ks_done = mock_done | spur;

    always_comb begin
        ks_in = '0;
        for (int i = 0; i < 16; i++) begin
            ks_in[i*32 +: 32] = spur ? garbage[i*32 +: 32] : ks_word(mock_ctr, i);
        end
    end

    // ---------------- output-ready driver ----------------
    bit or_rand = 1'b0;
    bit force_stall = 1'b0;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_stall ? 1'b0 : (or_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // ---------------- model state and compare process ----------------
    logic [31:0] model_ctr = 32'd0;
    logic [32:0] exp_q[$];
    logic [31:0] exp_ctr_q[$];
    logic [31:0] got_q[$];
    logic        got_last_q[$];
    logic [31:0] start_q[$];
    int          stall_cycles = 0;

    initial begin
        logic        stall_prev;
        logic [31:0] stall_data;
        logic        stall_last;
        logic [32:0] e;
        logic [31:0] ec;
        stall_prev = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, stall_data);
                    check("hold_last", out_last, stall_last);
                end
                if (out_valid && !out_ready) begin
                    check("in_ready_bp", in_ready, 0);
                    stall_cycles++;
                end
                if (!busy) check("in_ready_idle", in_ready, 0);
                if (core_start) begin
                    start_q.push_back(core_counter);
                    if (exp_ctr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL start_extra: got start ctr=%0h want no start", core_counter);
                    end else begin
                        ec = exp_ctr_q.pop_front();
                        check("start_ctr", core_counter, ec);
                    end
                end
                if (out_valid && out_ready) begin
                    got_q.push_back(out_data);
                    got_last_q.push_back(out_last);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL out_extra: got word %0h want none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e[31:0]);
                        check("out_last", out_last, e[32]);
                    end
                end
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
                stall_last = out_last;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_core_start", core_start, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_counter", core_counter, 0);
        exp_q.delete();
        exp_ctr_q.delete();
        model_ctr = 32'd0;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [31:0] c);
        init = 1'b1;
        ctr_init = c;
        @(posedge clk);
        #1;
        init = 1'b0;
        model_ctr = c;
        check("init_ctr", core_counter, c);
    endtask

    // rst_mode: 0 none, 1 reset while waiting for the core, 2 reset after rst_k accepted words
    task automatic send_msg(input int n, input bit rnd, input logic [31:0] pat, input logic [31:0] step,
                            input bit noise, input int rst_mode, input int rst_k);
        logic [31:0] d[$];
        int bl;
        int budget;
        bit acc;
        bl = (n + 15) / 16;
        for (int k = 0; k < n; k++) begin
            d.push_back(rnd ? $urandom : pat + step * k);
            exp_q.push_back({(k == n - 1), d[k] ^ ks_word(model_ctr + 32'(k / 16), k % 16)});
        end
        for (int b = 0; b < bl; b++) exp_ctr_q.push_back(model_ctr + 32'(b));
        model_ctr = model_ctr + 32'(bl);
        if (rst_mode == 1) begin
            in_valid = 1'b1;
            in_data = d[0];
            in_last = (n == 1);
            repeat (3) @(posedge clk);
            #2;
            do_reset();
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data = d[k];
            in_last = (k == n - 1);
            acc = 1'b0;
            budget = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_ready;
                if (noise && busy && $urandom_range(0, 2) == 0) begin
                    init = 1'b1;
                    ctr_init = $urandom;
                end
                if (noise && (in_ready || !busy) && $urandom_range(0, 2) == 0) begin
                    for (int i = 0; i < 16; i++) garbage[i*32 +: 32] = $urandom;
                    spur = 1'b1;
                end
                @(posedge clk);
                #1;
                init = 1'b0;
                spur = 1'b0;
                budget++;
                if (!acc && budget > 200) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: word %0d not accepted after %0d cycles, want accept", k, budget);
                    in_valid = 1'b0;
                    in_last = 1'b0;
                    return;
                end
            end
            if (rst_mode == 2 && k + 1 == rst_k) begin
                #1;
                do_reset();
                return;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 400) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_left", exp_q.size(), 0);
        check("ctr_q_left", exp_ctr_q.size(), 0);
        exp_q.delete();
        exp_ctr_q.delete();
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_last_q.delete();
        start_q.delete();
    endtask

    task automatic scen1();
        mix = 1'b0;
        do_init(32'd5);
        clear_logs();
        send_msg(3, 1'b0, 32'd0, 32'd1, 1'b0, 0, 0);
        drain();
        check("s1_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("s1_w0", got_q[0], 32'h5);
            check("s1_w1", got_q[1], 32'h4);
            check("s1_w2", got_q[2], 32'h7);
            check("s1_last0", got_last_q[0], 0);
            check("s1_last2", got_last_q[2], 1);
        end
        check("s1_counter", core_counter, 32'd6);
        check("s1_idle", busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] w;
        logic [31:0] keep;
        reset = 1'b1;
        init = 1'b0;
        ctr_init = '0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("init_core_start", core_start, 0);
        check("init_in_ready", in_ready, 0);
        check("init_out_valid", out_valid, 0);
        check("init_out_data", out_data, 0);
        check("init_out_last", out_last, 0);
        check("init_busy", busy, 0);
        check("init_counter", core_counter, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        scen1();

        // two blocks, counter 0 then 1
        do_init(32'd0);
        clear_logs();
        send_msg(20, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 0);
        drain();
        check("s2_count", got_q.size(), 20);
        if (got_q.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                w = (i < 16) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
                check($sformatf("s2_w%0d", i), got_q[i], w);
            end
        end
        check("s2_starts", start_q.size(), 2);
        if (start_q.size() == 2) begin
            check("s2_ctr0", start_q[0], 32'd0);
            check("s2_ctr1", start_q[1], 32'd1);
        end

        // backpressure mid-block
        mix = 1'b1;
        do_init(32'd100);
        clear_logs();
        stall_cycles = 0;
        fork
            send_msg(20, 1'b1, 32'd0, 32'd0, 1'b0, 0, 0);
            begin
                repeat (12) @(posedge clk);
                force_stall = 1'b1;
                repeat (5) @(posedge clk);
                force_stall = 1'b0;
            end
        join
        drain();
        check("s3_count", got_q.size(), 20);
        check("s3_stalled", (stall_cycles >= 4), 1);

        // counter wrap
        do_init(32'hFFFF_FFFF);
        clear_logs();
`ifdef CHACHA20_CTR_WRAP_ERR_EN
        send_msg(16, 1'b1, 32'd0, 32'd0, 1'b0, 0, 0);
        drain();
        check("s4_wrap_err", ctr_wrap_err, 1);
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("s4_blocked", in_ready, 0);
            check("s4_idle", busy, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do_init(32'd0);
        check("s4_err_clear", ctr_wrap_err, 0);
`else
        send_msg(17, 1'b1, 32'd0, 32'd0, 1'b0, 0, 0);
        drain();
        check("s4_starts", start_q.size(), 2);
        if (start_q.size() == 2) begin
            check("s4_ctr0", start_q[0], 32'hFFFF_FFFF);
            check("s4_ctr1", start_q[1], 32'd0);
        end
        check("s4_counter", core_counter, 32'd1);
`endif

        // reset while waiting for the core, then while streaming
        do_init(32'd9);
        send_msg(5, 1'b1, 32'd0, 32'd0, 1'b0, 1, 0);
        scen1();
        mix = 1'b1;
        do_init(32'd9);
        send_msg(20, 1'b1, 32'd0, 32'd0, 1'b0, 2, 6);
        scen1();

        // spurious ks_done in IDLE is ignored
        keep = 32'd42;
        do_init(keep);
        for (int i = 0; i < 16; i++) garbage[i*32 +: 32] = $urandom;
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        @(posedge clk);
        #1;
        check("s6_idle", busy, 0);
        check("s6_counter", core_counter, keep);

        // random messages with init/ks_done noise and random backpressure
        mix = 1'b1;
        or_rand = 1'b1;
        for (int m = 0; m < 12; m++) begin
            send_msg($urandom_range(1, 40), 1'b1, 32'd0, 32'd0, 1'b1, 0, 0);
            drain();
            check($sformatf("rnd_counter%0d", m), core_counter, model_ctr);
        end
        or_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
